tag_verifier: RTL and testbench

//   Final authentication stage fed by the polynomial hash stage. Accepts one 192-bit tag (LAMBDA lanes of 32 bits),

---
 rtl/tag_verifier.sv | 150 +++++++++++++++
 tb/tb_tag_verifier.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/tag_verifier.sv
// Final authentication stage: reduces each hash lane mod 2^OMEGA-1, adds a one-time pad lane,
// collects the received tag from a byte stream and reports match/mismatch on a held result port.
module tag_verifier #(
  parameter int unsigned LAMBDA        = 6,
  parameter int unsigned OMEGA         = 31,
  parameter int unsigned TAGP_LENGTH   = 192,
  parameter int unsigned PAD_LENGTH    = 186,
  parameter int unsigned MESSAGE_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [TAGP_LENGTH-1:0]   tagp_tdata,
  input  logic                     tagp_tvalid,
  output logic                     tagp_tready,
  input  logic [PAD_LENGTH-1:0]    pad_key,
  input  logic [MESSAGE_WIDTH-1:0] rx_tdata,
  input  logic                     rx_tvalid,
  output logic                     rx_tready,
  output logic [TAGP_LENGTH-1:0]   tag_tdata,
  output logic                     result_pass,
  output logic                     result_tvalid,
  input  logic                     result_tready
);

  localparam int unsigned LANE_W  = TAGP_LENGTH / LAMBDA;
  localparam int unsigned BEATS   = TAGP_LENGTH / MESSAGE_WIDTH;
  localparam int unsigned LANE_CW = $clog2(LAMBDA);
  localparam int unsigned BYTE_CW = $clog2(BEATS + 1);
  localparam logic [LANE_W-1:0] P_EXT = LANE_W'({OMEGA{1'b1}});
  localparam logic [OMEGA-1:0]  P     = {OMEGA{1'b1}};

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_COMPUTE = 3'd1;
  localparam logic [2:0] S_COLLECT = 3'd2;
  localparam logic [2:0] S_COMPARE = 3'd3;
  localparam logic [2:0] S_RESULT  = 3'd4;

  logic [2:0]             state, state_nxt;
  logic [LANE_CW-1:0]     lane_cnt, lane_cnt_nxt;
  logic [BYTE_CW-1:0]     byte_cnt, byte_cnt_nxt;
  logic                   tag_acc, rx_acc;
  logic [TAGP_LENGTH-1:0] tag_q;
  logic [TAGP_LENGTH-1:0] rx_q;
  logic [LANE_W-1:0]      lane_x, red_r, sum_s;
  logic [OMEGA-1:0]       pad_k;
  logic                   lanes_match;

  // Next-state and handshake decode; start overrides everything
  always_comb begin
    state_nxt    = state;
    lane_cnt_nxt = lane_cnt;
    byte_cnt_nxt = byte_cnt;
    tag_acc      = 1'b0;
    rx_acc       = rx_tvalid && rx_tready;
    if (rx_acc) byte_cnt_nxt = byte_cnt + BYTE_CW'(1);
    case (state)
      S_IDLE: begin
        if (tagp_tvalid && tagp_tready) begin
          tag_acc      = 1'b1;
          state_nxt    = S_COMPUTE;
          lane_cnt_nxt = '0;
          byte_cnt_nxt = '0;
        end
      end
      S_COMPUTE: begin
        if (lane_cnt == LANE_CW'(LAMBDA - 1)) begin
          state_nxt    = S_COLLECT;
          lane_cnt_nxt = '0;
        end else begin
          lane_cnt_nxt = lane_cnt + LANE_CW'(1);
        end
      end
      S_COLLECT: if (byte_cnt == BYTE_CW'(BEATS)) state_nxt = S_COMPARE;
      S_COMPARE: state_nxt = S_RESULT;
      S_RESULT:  if (result_tready) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
    if (start) begin
      state_nxt    = S_IDLE;
      lane_cnt_nxt = '0;
      byte_cnt_nxt = '0;
      tag_acc      = 1'b0;
      rx_acc       = 1'b0;
    end
  end

  // Per-lane modular reduction and pad addition for the lane selected by lane_cnt
  always_comb begin
    lane_x = '0;
    pad_k  = '0;
    for (int i = 0; i < LAMBDA; i++) begin
      if (lane_cnt == LANE_CW'(i)) begin
        lane_x = tag_q[LANE_W*i +: LANE_W];
        pad_k  = pad_key[PAD_LENGTH-1-OMEGA*i -: OMEGA];
      end
    end
    red_r = {1'b0, lane_x[OMEGA-1:0]} + LANE_W'(lane_x[LANE_W-1]);
    if (red_r >= P_EXT) red_r = red_r - P_EXT;
    if (pad_k == P) pad_k = '0;
    sum_s = red_r + {1'b0, pad_k};
    if (sum_s >= P_EXT) sum_s = sum_s - P_EXT;
  end

  // Lane-wise compare; a received lane with its top bit set can never match
  always_comb begin
    lanes_match = 1'b1;
    for (int i = 0; i < LAMBDA; i++) begin
      if (rx_q[LANE_W*i +: LANE_W] != tag_tdata[LANE_W*i +: LANE_W]) lanes_match = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      lane_cnt <= '0;
      byte_cnt <= '0;
    end else begin
      state    <= state_nxt;
      lane_cnt <= lane_cnt_nxt;
      byte_cnt <= byte_cnt_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_q         <= '0;
      rx_q          <= '0;
      tag_tdata     <= '0;
      result_pass   <= 1'b0;
      result_tvalid <= 1'b0;
      rx_tready     <= 1'b0;
      tagp_tready   <= 1'b1;
    end else begin
      tagp_tready   <= (state_nxt == S_IDLE);
      rx_tready     <= ((state_nxt == S_COMPUTE) || (state_nxt == S_COLLECT)) &&
                       (byte_cnt_nxt < BYTE_CW'(BEATS));
      result_tvalid <= (state_nxt == S_RESULT);
      if (tag_acc) tag_q <= tagp_tdata;
      if (rx_acc) rx_q <= {rx_q[TAGP_LENGTH-MESSAGE_WIDTH-1:0], rx_tdata};
      if ((state == S_COMPUTE) && !start) begin
        for (int i = 0; i < LAMBDA; i++) begin
          if (lane_cnt == LANE_CW'(i)) tag_tdata[LANE_W*i +: LANE_W] <= sum_s;
        end
      end
      if ((state == S_COMPARE) && !start) result_pass <= lanes_match;
    end
  end

endmodule

// File: tb/tb_tag_verifier.sv
// Directed bench for tag_verifier: hand-computed lane reductions, stream collection and result handshake.
module tb_tag_verifier;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [191:0] tagp_tdata;
  logic         tagp_tvalid;
  logic         tagp_tready;
  logic [185:0] pad_key;
  logic [7:0]   rx_tdata;
  logic         rx_tvalid;
  logic         rx_tready;
  logic [191:0] tag_tdata;
  logic         result_pass;
  logic         result_tvalid;
  logic         result_tready;

  int errors = 0;
  int checks = 0;

  logic [191:0] tag3, exp3, tag4, rx4, tag5, exp5, bad5;
  logic [185:0] pad3, pad4, pad5;

  always #5 clk = ~clk;

  tag_verifier dut (
    .clk(clk), .rst(rst), .start(start),
    .tagp_tdata(tagp_tdata), .tagp_tvalid(tagp_tvalid), .tagp_tready(tagp_tready),
    .pad_key(pad_key),
    .rx_tdata(rx_tdata), .rx_tvalid(rx_tvalid), .rx_tready(rx_tready),
    .tag_tdata(tag_tdata), .result_pass(result_pass),
    .result_tvalid(result_tvalid), .result_tready(result_tready)
  );

  task automatic check(input string name, input logic [191:0] obs, input logic [191:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_tag(input logic [191:0] t, input logic [185:0] p);
    int n;
    pad_key     = p;
    tagp_tdata  = t;
    tagp_tvalid = 1'b1;
    n = 0;
    while (!tagp_tready && n < 50) begin tick(); n++; end
    check("tagp_handshake", 192'(tagp_tready), 192'd1);
    tick();
    tagp_tvalid = 1'b0;
  endtask

  task automatic send_bytes(input logic [191:0] r, input int nb);
    int n;
    for (int j = 0; j < nb; j++) begin
      rx_tdata  = r[191-8*j -: 8];
      rx_tvalid = 1'b1;
      n = 0;
      while (!rx_tready && n < 50) begin tick(); n++; end
      check("rx_handshake", 192'(rx_tready), 192'd1);
      tick();
    end
    rx_tvalid = 1'b0;
  endtask

  task automatic wait_result();
    int n;
    n = 0;
    while (!result_tvalid && n < 50) begin tick(); n++; end
    check("result_tvalid_rise", 192'(result_tvalid), 192'd1);
  endtask

  task automatic accept_result();
    result_tready = 1'b1;
    tick();
    result_tready = 1'b0;
    check("result_tvalid_drop", 192'(result_tvalid), 192'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0;
    tagp_tdata = '0; tagp_tvalid = 1'b0; pad_key = '0;
    rx_tdata = '0; rx_tvalid = 1'b0; result_tready = 1'b0;

    tag3 = 192'hFFFFFFFF;
    pad3 = 186'd5 << 155;
    exp3 = 192'h6;
    tag4 = 192'h7FFFFFFF << 32;
    pad4 = 186'h7FFFFFFF << 124;
    rx4  = 192'h80000000 << 32;
    tag5 = (192'h80000005 << 96) | (192'h12345678 << 64);
    pad5 = (186'h7FFFFFFC << 62) | (186'h10 << 93);
    exp5 = (192'h3 << 96) | (192'h12345688 << 64);
    bad5 = exp5 ^ (192'hFF << 80);

    // Reset values
    repeat (3) tick();
    check("rst_tagp_tready", 192'(tagp_tready), 192'd1);
    check("rst_rx_tready", 192'(rx_tready), 192'd0);
    check("rst_result_tvalid", 192'(result_tvalid), 192'd0);
    check("rst_result_pass", 192'(result_pass), 192'd0);
    check("rst_tag_tdata", tag_tdata, 192'd0);
    rst = 1'b0;
    tick();

    // All-zero tag and pad, back-to-back bytes; exact latency after last byte
    send_tag('0, '0);
    check("compute_tagp_tready", 192'(tagp_tready), 192'd0);
    send_bytes('0, 24);
    check("zero_rx_tready_full", 192'(rx_tready), 192'd0);
    check("zero_tvalid_e24", 192'(result_tvalid), 192'd0);
    tick();
    check("zero_tvalid_e25", 192'(result_tvalid), 192'd0);
    tick();
    check("zero_tvalid_e26", 192'(result_tvalid), 192'd1);
    check("zero_pass", 192'(result_pass), 192'd1);
    check("zero_tag", tag_tdata, 192'd0);
    accept_result();

    // Lane0 top bit folds in, pad lane0 = 5 -> t_0 = 6
    send_tag(tag3, pad3);
    send_bytes(exp3, 24);
    wait_result();
    check("lane0_pass", 192'(result_pass), 192'd1);
    check("lane0_tag", tag_tdata, exp3);
    accept_result();

    // Lane1 = p and pad = p both reduce to 0; received lane with bit31 set fails; held result
    send_tag(tag4, pad4);
    send_bytes(rx4, 24);
    wait_result();
    check("lane1_pass", 192'(result_pass), 192'd0);
    check("lane1_tag", tag_tdata, 192'd0);
    for (int c = 0; c < 5; c++) begin
      tick();
      check("hold_tvalid", 192'(result_tvalid), 192'd1);
      check("hold_pass", 192'(result_pass), 192'd0);
      check("hold_tag", tag_tdata, 192'd0);
    end
    accept_result();
    check("after_tagp_tready", 192'(tagp_tready), 192'd1);

    // Multi-lane tag with wrap on pad addition
    send_tag(tag5, pad5);
    send_bytes(exp5, 24);
    wait_result();
    check("multi_pass", 192'(result_pass), 192'd1);
    check("multi_tag", tag_tdata, exp5);
    accept_result();
    check("multi_pass_kept", 192'(result_pass), 192'd1);
    check("multi_tag_kept", tag_tdata, exp5);

    // Same tag with one received byte flipped
    send_tag(tag5, pad5);
    send_bytes(bad5, 24);
    wait_result();
    check("flip_pass", 192'(result_pass), 192'd0);
    check("flip_tag", tag_tdata, exp5);
    accept_result();

    // Abort after 10 bytes; byte offered alongside start is dropped
    send_tag(tag3, pad3);
    send_bytes(exp3, 10);
    rx_tdata  = 8'hAA;
    rx_tvalid = 1'b1;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    rx_tvalid = 1'b0;
    check("abort_rx_tready", 192'(rx_tready), 192'd0);
    check("abort_tagp_tready", 192'(tagp_tready), 192'd1);
    check("abort_tvalid", 192'(result_tvalid), 192'd0);
    repeat (3) tick();
    check("abort_idle_rx_tready", 192'(rx_tready), 192'd0);

    // Full retry after abort
    send_tag(tag3, pad3);
    send_bytes(exp3, 24);
    wait_result();
    check("retry_pass", 192'(result_pass), 192'd1);
    check("retry_tag", tag_tdata, exp3);
    accept_result();

    // Asynchronous reset mid-collection
    send_tag(tag5, pad5);
    send_bytes(exp5, 5);
    rst = 1'b1;
    #1;
    check("arst_tagp_tready", 192'(tagp_tready), 192'd1);
    check("arst_rx_tready", 192'(rx_tready), 192'd0);
    check("arst_tag", tag_tdata, 192'd0);
    check("arst_pass", 192'(result_pass), 192'd0);
    #2;
    rst = 1'b0;
    tick();

    // Clean run after reset
    send_tag(tag5, pad5);
    send_bytes(exp5, 24);
    wait_result();
    check("post_rst_pass", 192'(result_pass), 192'd1);
    check("post_rst_tag", tag_tdata, exp5);
    accept_result();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
